huffman_freq_sort: RTL and testbench

- Upstream stage of create_node_code in the 4-symbol Huffman datapath.
- Counts occurrences of symbols A..D in an input stream, then sorts the four counts ascending.
- Presents the result as the four 13-bit leaf words leaf_A..leaf_D, plus the 2-bit state that create_node_code consumes.
- leaf_A always holds the lowest weight.

---
 rtl/huffman_freq_sort.sv | 176 +++++++++++++++++
 tb/tb_huffman_freq_sort.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_freq_sort.sv
// huffman_freq_sort: upstream stage of create_node_code in the 4-symbol
// Huffman datapath. It counts symbols A..D in a block, then bubble-sorts the
// four counts ascending over six compare-swap cycles. The result is presented
// as four 13-bit leaf words {5'b0, count, symbol ID}, with leaf_A holding the
// lowest weight.
// Optional build macro FREQ_OVF_EN adds a sticky freq_ovf output. It reports
// any increment attempted on a counter that is already saturated.
module huffman_freq_sort #(
    parameter logic [3:0] SYM_BASE = 4'hA,
    parameter logic [3:0] CNT_MAX  = 4'd15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        sym_valid,
    input  logic [1:0]  sym_in,
    input  logic        sym_last,
    output logic        sym_ready,
`ifdef FREQ_OVF_EN
    output logic        freq_ovf,
`endif
    output logic [1:0]  state,
    output logic [12:0] leaf_A,
    output logic [12:0] leaf_B,
    output logic [12:0] leaf_C,
    output logic [12:0] leaf_D
);

    typedef enum logic [1:0] {
        ST_COUNT = 2'b00,
        ST_SORT  = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t cur_state;
    state_t next_state;

    // Counts and symbol indices share one working array. While counting, the
    // array is in identity order, so slot i is symbol i. While sorting, the
    // counts and their symbol indices move together.
    logic [3:0] cnt [4];
    logic [1:0] sym [4];
    logic [2:0] pass_cnt;

    logic [1:0] lo_idx;
    logic [1:0] hi_idx;
    logic [3:0] sw_cnt [4];
    logic [1:0] sw_sym [4];

    logic accept;
    logic clear;

    assign accept = (cur_state == ST_COUNT) && !start && sym_valid;
    assign clear  = start && (cur_state != ST_SORT);
    assign state  = cur_state;

    // Phase register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur_state <= ST_COUNT;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-phase selection and handshake output
    always_comb begin
        next_state = cur_state;
        sym_ready  = 1'b0;
        case (cur_state)
            ST_COUNT: begin
                sym_ready = 1'b1;
                if (!start && sym_valid && sym_last) begin
                    next_state = ST_SORT;
                end
            end
            ST_SORT: begin
                if (pass_cnt == 3'd5) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    next_state = ST_COUNT;
                end
            end
            default: begin
                next_state = ST_COUNT;
            end
        endcase
    end

    // Pick this pass's compare pair; the sequence is three bubble passes of length 3, 2, 1
    always_comb begin
        lo_idx = 2'd0;
        case (pass_cnt)
            3'd0:    lo_idx = 2'd0;
            3'd1:    lo_idx = 2'd1;
            3'd2:    lo_idx = 2'd2;
            3'd3:    lo_idx = 2'd0;
            3'd4:    lo_idx = 2'd1;
            default: lo_idx = 2'd0;
        endcase
        hi_idx = lo_idx + 2'd1;
    end

    // Compare-swap of the selected pair; equal counts stay put, which keeps ties in symbol order
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sw_cnt[i] = cnt[i];
            sw_sym[i] = sym[i];
        end
        if (cnt[lo_idx] > cnt[hi_idx]) begin
            sw_cnt[lo_idx] = cnt[hi_idx];
            sw_cnt[hi_idx] = cnt[lo_idx];
            sw_sym[lo_idx] = sym[hi_idx];
            sw_sym[hi_idx] = sym[lo_idx];
        end
    end

    // Working array: counts up in COUNT and one compare-swap per cycle in SORT
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= 4'd0;
                sym[i] <= 2'(i);
            end
            pass_cnt <= 3'd0;
        end else if (clear) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= 4'd0;
                sym[i] <= 2'(i);
            end
            pass_cnt <= 3'd0;
        end else if (accept) begin
            if (cnt[sym_in] != CNT_MAX) begin
                cnt[sym_in] <= cnt[sym_in] + 4'd1;
            end
        end else if (cur_state == ST_SORT) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= sw_cnt[i];
                sym[i] <= sw_sym[i];
            end
            pass_cnt <= (pass_cnt == 3'd5) ? 3'd0 : pass_cnt + 3'd1;
        end
    end

    // Leaf outputs capture the final swap result on entry to DONE and hold until the next one
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            leaf_A <= 13'h0000;
            leaf_B <= 13'h0000;
            leaf_C <= 13'h0000;
            leaf_D <= 13'h0000;
        end else if ((cur_state == ST_SORT) && (pass_cnt == 3'd5)) begin
            leaf_A <= {5'b0, sw_cnt[0], SYM_BASE + {2'b00, sw_sym[0]}};
            leaf_B <= {5'b0, sw_cnt[1], SYM_BASE + {2'b00, sw_sym[1]}};
            leaf_C <= {5'b0, sw_cnt[2], SYM_BASE + {2'b00, sw_sym[2]}};
            leaf_D <= {5'b0, sw_cnt[3], SYM_BASE + {2'b00, sw_sym[3]}};
        end
    end

`ifdef FREQ_OVF_EN
    // Sticky overflow: any accepted symbol whose counter is already saturated
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            freq_ovf <= 1'b0;
        end else if (clear) begin
            freq_ovf <= 1'b0;
        end else if (accept && (cnt[sym_in] == CNT_MAX)) begin
            freq_ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_huffman_freq_sort.sv
// Self-checking bench for huffman_freq_sort: table vectors, hand-written
// control/reset sequences, and randomized blocks against a selection-sort model.
module tb_huffman_freq_sort;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        sym_valid;
    logic [1:0]  sym_in;
    logic        sym_last;
    logic        sym_ready;
    logic [1:0]  state;
    logic [12:0] leaf_A;
    logic [12:0] leaf_B;
    logic [12:0] leaf_C;
    logic [12:0] leaf_D;
`ifdef FREQ_OVF_EN
    logic        freq_ovf;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [3:0][1:0]  order;
        logic [3:0][4:0]  reps;
        logic [3:0][12:0] exp;
        logic             exp_ovf;
    } vec_t;

    vec_t  tbl [4];
    string tname [4];

    huffman_freq_sort dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .sym_valid (sym_valid),
        .sym_in    (sym_in),
        .sym_last  (sym_last),
        .sym_ready (sym_ready),
`ifdef FREQ_OVF_EN
        .freq_ovf  (freq_ovf),
`endif
        .state     (state),
        .leaf_A    (leaf_A),
        .leaf_B    (leaf_B),
        .leaf_C    (leaf_C),
        .leaf_D    (leaf_D)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] s, input logic l, input logic st);
        sym_valid = v;
        sym_in    = s;
        sym_last  = l;
        start     = st;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkLeaves(input string name, input logic [12:0] exp [4]);
        checkOutput({name, " leaf_A"}, 32'(leaf_A), 32'(exp[0]));
        checkOutput({name, " leaf_B"}, 32'(leaf_B), 32'(exp[1]));
        checkOutput({name, " leaf_C"}, 32'(leaf_C), 32'(exp[2]));
        checkOutput({name, " leaf_D"}, 32'(leaf_D), 32'(exp[3]));
    endtask

    // Reference: saturating counts, then repeatedly pick the smallest remaining (lowest index on ties)
    function automatic void modelLeaves(input logic [1:0] syms [$], output logic [12:0] exp [4],
                                        output logic ovf);
        int c [4];
        bit used [4];
        int best;
        ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c[i] = 0;
            used[i] = 1'b0;
        end
        foreach (syms[k]) begin
            if (c[syms[k]] == 15) ovf = 1'b1;
            else c[syms[k]]++;
        end
        for (int k = 0; k < 4; k++) begin
            best = -1;
            for (int i = 0; i < 4; i++) begin
                if (!used[i] && (best < 0 || c[i] < c[best])) best = i;
            end
            used[best] = 1'b1;
            exp[k] = {5'b0, 4'(c[best]), 4'(4'hA + best)};
        end
    endfunction

    // Called right after the edge that accepted sym_last: checks SORT, latency to DONE, then leaves
    task automatic waitDone(input string name, input logic [12:0] exp [4], input logic exp_ovf,
                            input bit noise);
        int cyc = 0;
        checkOutput({name, " state SORT"}, 32'(state), 32'h1);
        checkOutput({name, " sym_ready in SORT"}, 32'(sym_ready), 32'h0);
        while (state !== 2'b10 && cyc < 20) begin
            if (noise) applyStimulus(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
            else applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
            cyc++;
        end
        checkOutput({name, " cycles to DONE"}, 32'(cyc), 32'd6);
        checkLeaves(name, exp);
`ifdef FREQ_OVF_EN
        checkOutput({name, " freq_ovf"}, 32'(freq_ovf), 32'(exp_ovf));
`else
        if (exp_ovf) begin end
`endif
    endtask

    task automatic runBlock(input string name, input logic [1:0] syms [$], input logic [12:0] exp [4],
                            input logic exp_ovf, input bit gaps, input bit noise);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
        checkOutput({name, " state after start"}, 32'(state), 32'h0);
        foreach (syms[i]) begin
            if (gaps && $urandom_range(0, 3) == 0)
                applyStimulus(1'b0, 2'($urandom), 1'($urandom), 1'b0);
            applyStimulus(1'b1, syms[i], (i == syms.size() - 1), 1'b0);
        end
        waitDone(name, exp, exp_ovf, noise);
    endtask

    task automatic setVec(input int idx, input string nm, input logic [3:0][1:0] order,
                          input logic [3:0][4:0] reps, input logic [3:0][12:0] exp, input logic ovf);
        tname[idx]       = nm;
        tbl[idx].order   = order;
        tbl[idx].reps    = reps;
        tbl[idx].exp     = exp;
        tbl[idx].exp_ovf = ovf;
    endtask

    initial begin
        logic [1:0]  q [$];
        logic [12:0] exp [4];
        logic        ovf;
        logic [1:0]  fav;

        // Packed arrays list element 3 first
        setVec(0, "basic",   {2'd3, 2'd2, 2'd1, 2'd0}, {5'd3, 5'd2, 5'd1, 5'd1},
               {13'h03D, 13'h02C, 13'h01B, 13'h01A}, 1'b0);
        setVec(1, "reverse", {2'd0, 2'd1, 2'd2, 2'd3}, {5'd4, 5'd3, 5'd2, 5'd1},
               {13'h04A, 13'h03B, 13'h02C, 13'h01D}, 1'b0);
        setVec(2, "ties",    {2'd3, 2'd1, 2'd2, 2'd0}, {5'd0, 5'd0, 5'd2, 5'd2},
               {13'h02C, 13'h02A, 13'h00D, 13'h00B}, 1'b0);
        setVec(3, "saturate", {2'd3, 2'd2, 2'd0, 2'd1}, {5'd0, 5'd0, 5'd1, 5'd20},
               {13'h0FB, 13'h01A, 13'h00D, 13'h00C}, 1'b1);

        RST = 1'b1; start = 1'b0; sym_valid = 1'b0; sym_in = 2'd0; sym_last = 1'b0;
        #12;
        checkOutput("reset state", 32'(state), 32'h0);
        checkOutput("reset sym_ready", 32'(sym_ready), 32'h1);
        checkOutput("reset leaf_A", 32'(leaf_A), 32'h0);
        checkOutput("reset leaf_D", 32'(leaf_D), 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;

        for (int v = 0; v < 4; v++) begin
            q.delete();
            for (int p = 0; p < 4; p++)
                for (int r = 0; r < int'(tbl[v].reps[p]); r++) q.push_back(tbl[v].order[p]);
            for (int k = 0; k < 4; k++) exp[k] = tbl[v].exp[k];
            runBlock(tname[v], q, exp, tbl[v].exp_ovf, 1'b0, 1'b0);
        end
`ifdef FREQ_OVF_EN
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
        checkOutput("start clears freq_ovf", 32'(freq_ovf), 32'h0);
`endif

        // Sequence: DONE ignores symbols; start returns to COUNT with leaves held
        q.delete(); q.push_back(2'd2); q.push_back(2'd2); q.push_back(2'd1);
        modelLeaves(q, exp, ovf);
        runBlock("pre-control", q, exp, ovf, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'($urandom), 1'($urandom), 1'b0);
            checkOutput("DONE holds state", 32'(state), 32'h2);
            checkOutput("DONE holds leaf_D", 32'(leaf_D), 32'h02C);
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
        checkOutput("start in DONE state", 32'(state), 32'h0);
        checkOutput("start in DONE leaf_D held", 32'(leaf_D), 32'h02C);
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
        exp = '{13'h00A, 13'h00C, 13'h00D, 13'h01B};
        waitDone("after DONE", exp, 1'b0, 1'b0);

        // Sequence: start in COUNT wins over a same-cycle last symbol
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd3, 1'b1, 1'b1);
        checkOutput("start priority state", 32'(state), 32'h0);
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
        exp = '{13'h00B, 13'h00C, 13'h00D, 13'h01A};
        waitDone("start priority", exp, 1'b0, 1'b0);

        // Sequence: reset mid-stream, then a block without start counts from zero
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        #2 RST = 1'b1;
        #1;
        checkOutput("mid reset state", 32'(state), 32'h0);
        checkOutput("mid reset sym_ready", 32'(sym_ready), 32'h1);
        checkOutput("mid reset leaf_A", 32'(leaf_A), 32'h0);
        checkOutput("mid reset leaf_B", 32'(leaf_B), 32'h0);
        checkOutput("mid reset leaf_C", 32'(leaf_C), 32'h0);
        checkOutput("mid reset leaf_D", 32'(leaf_D), 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
        exp = '{13'h00C, 13'h00D, 13'h01A, 13'h01B};
        waitDone("after reset", exp, 1'b0, 1'b0);

        // Sequence: reset during SORT discards the partial sort
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        #2 RST = 1'b1;
        #1;
        checkOutput("sort reset state", 32'(state), 32'h0);
        checkOutput("sort reset leaf_D", 32'(leaf_D), 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;
        applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
        exp = '{13'h00A, 13'h00B, 13'h00C, 13'h01D};
        waitDone("after sort reset", exp, 1'b0, 1'b0);

        // Randomized blocks, biased toward one symbol so saturation occurs
        for (int t = 0; t < 30; t++) begin
            q.delete();
            fav = 2'($urandom);
            for (int i = 0; i < int'($urandom_range(1, 40)); i++)
                q.push_back(($urandom_range(0, 2) == 0) ? 2'($urandom) : fav);
            modelLeaves(q, exp, ovf);
            runBlock($sformatf("random %0d", t), q, exp, ovf, 1'b1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
